// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, constants and sizing helpers for the instruction fetch unit.
package inst_fetch_unit_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_ADDR_W-1:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic [INST_W-1:0]      NOP_INST         = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  // Pointer width for a queue of the given depth (at least one bit).
  function automatic int fetch_depth_log2(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of an occupancy counter able to hold 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_chk.sv
// Simulation-only protocol and bookkeeping invariants for inst_fetch_unit.
module inst_fetch_unit_chk #(
  parameter int CNT_W      = 3,
  parameter int TAG_W      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             rvalid,
  input logic [CNT_W-1:0] outst,
  input logic [CNT_W-1:0] drop,
  input logic [CNT_W-1:0] fifo_count,
  input logic [TAG_W-1:0] tag_count
);

  a_rvalid_needs_outst : assert property (@(posedge clk) disable iff (rst)
    !(rvalid && (outst == '0)));

  a_occupancy_bound : assert property (@(posedge clk) disable iff (rst)
    (({1'b0, fifo_count} + {1'b0, outst}) <= (CNT_W + 1)'(FIFO_DEPTH)));

  // Every outstanding request that will not be dropped owns exactly one tag.
  a_tags_match : assert property (@(posedge clk) disable iff (rst)
    (CNT_W'(tag_count) == (outst - drop)));

endmodule

// File: rtl/inst_fetch_unit_fifo.sv
// Synchronous FIFO with clear and occupancy count; used for prefetch data and fetch tags.
module inst_fetch_unit_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = fetch_depth_log2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push  = push && (count != FULL_CNT);
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clr && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Clear has the same effect as reset and overrides a same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC generation, req/gnt/rvalid fetch, prefetch FIFO and registered output to decode.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int TAG_W = cnt_width(MAX_OUTST);
  localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] OUTST_LIM = CNT_W'(MAX_OUTST);

  logic [31:0]      pc;
  logic [CNT_W-1:0] outst;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] fifo_count;
  logic [TAG_W-1:0] tag_count;
  logic [31:0]      tag_head;
  logic [CNT_W:0]   occupancy;
  logic             grant;
  logic             resp;
  logic             take;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  assign occupancy  = {1'b0, fifo_count} + {1'b0, outst};
  assign mem_addr_o = pc;
  assign push_entry = '{pc: tag_head, inst: mem_rdata_i};

  // Request gating and handshake decode.
  always_comb begin
    mem_req_o = 1'b0;
    grant     = 1'b0;
    resp      = 1'b0;
    take      = 1'b0;
    pop       = 1'b0;
    if (!rst && !redirect_i && (occupancy < DEPTH_LIM) && (outst < OUTST_LIM)) begin
      mem_req_o = 1'b1;
    end else begin
      mem_req_o = 1'b0;
    end
    grant = mem_req_o && mem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp  = mem_rvalid_i && (outst != '0);
    take  = resp && (drop == '0) && !redirect_i;
    pop   = !redirect_i && !stall_i && (fifo_count != '0);
  end

  // PC, outstanding and drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      outst <= '0;
      drop  <= '0;
    end else begin
      if (redirect_i) begin
        pc <= redirect_pc_i & ~32'h0000_0003;
      end else if (grant) begin
        pc <= pc + 32'd4;
      end
      case ({grant, resp})
        2'b10:   outst <= outst + CNT_W'(1);
        2'b01:   outst <= outst - CNT_W'(1);
        default: outst <= outst;
      endcase
      // Requests still in flight at a redirect return stale words that must be discarded.
      if (redirect_i) begin
        drop <= outst - CNT_W'(resp);
      end else if (resp && (drop != '0)) begin
        drop <= drop - CNT_W'(1);
      end
    end
  end

  // Output register presented to decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_o <= 1'b0;
      if_pc_o    <= ZERO_WORD;
      if_inst_o  <= NOP_INST;
    end else if (redirect_i) begin
      if_valid_o <= 1'b0;
      if_pc_o    <= ZERO_WORD;
      if_inst_o  <= NOP_INST;
    end else if (!stall_i) begin
      if (pop) begin
        if_valid_o <= 1'b1;
        if_pc_o    <= head.pc;
        if_inst_o  <= head.inst;
      end else begin
        if_valid_o <= 1'b0;
        if_pc_o    <= ZERO_WORD;
        if_inst_o  <= NOP_INST;
      end
    end
  end

  inst_fetch_unit_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (redirect_i),
    .push      (take),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count)
  );

  // In-order addresses of granted, not-yet-returned requests.
  inst_fetch_unit_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTST),
    .CNT_W (TAG_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (redirect_i),
    .push      (grant),
    .push_data (pc),
    .pop       (take),
    .pop_data  (tag_head),
    .count     (tag_count)
  );

  inst_fetch_unit_chk #(
    .CNT_W      (CNT_W),
    .TAG_W      (TAG_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .rvalid     (mem_rvalid_i),
    .outst      (outst),
    .drop       (drop),
    .fifo_count (fifo_count),
    .tag_count  (tag_count)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with a simple in-order memory responder.
module tb_inst_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] pend[$];
  bit          auto_resp;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_inst_o     (if_inst_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record a handshake at the negedge, then answer the oldest request after the edge.
  task automatic tick();
    @(negedge clk);
    if (mem_req_o && mem_gnt_i) pend.push_back(mem_addr_o);
    @(posedge clk);
    #1;
    if (auto_resp && pend.size() > 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = pend.pop_front() ^ KEY;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
    end
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    auto_resp = 1'b1;

    repeat (3) tick();
    chk("rst_req", mem_req_o, 32'h0);
    chk("rst_valid", if_valid_o, 32'h0);
    chk("rst_pc", if_pc_o, 32'h0);
    chk("rst_inst", if_inst_o, 32'h0);

    rst = 1'b0; mem_gnt_i = 1'b1;
    #1;
    chk("rel_req", mem_req_o, 32'h1);
    chk("rel_addr", mem_addr_o, 32'h0);

    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("str_valid", if_valid_o, 32'h1);
      chk("str_pc", if_pc_o, 32'(4 * i));
      chk("str_inst", if_inst_o, 32'(4 * i) ^ KEY);
    end

    stall_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_hold_pc", if_pc_o, 32'h14);
      chk("stall_hold_inst", if_inst_o, 32'h14 ^ KEY);
    end
    chk("stall_req_off", mem_req_o, 32'h0);
    stall_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rel_valid", if_valid_o, 32'h1);
      chk("rel_pc", if_pc_o, 32'h18 + 32'(4 * i));
      chk("rel_inst", if_inst_o, (32'h18 + 32'(4 * i)) ^ KEY);
    end

    rst = 1'b1; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; pend.delete();
    tick(); tick();
    rst = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h10; mem_gnt_i = 1'b1; auto_resp = 1'b0;
    #1;
    chk("rd_req_blocked", mem_req_o, 32'h0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("rd_addr_10", mem_addr_o, 32'h10);
    tick(); tick();
    chk("outst_limit_req", mem_req_o, 32'h0);
    redirect_i = 1'b1; redirect_pc_i = 32'h103;
    tick();
    redirect_i = 1'b0;
    #1;
    chk("rd_nop_valid", if_valid_o, 32'h0);
    chk("rd_new_addr", mem_addr_o, 32'h100);
    auto_resp = 1'b1;
    for (int n = 0; n < 20 && !if_valid_o; n++) tick();
    chk("rd_first_valid", if_valid_o, 32'h1);
    chk("rd_first_pc", if_pc_o, 32'h100);
    chk("rd_first_inst", if_inst_o, 32'h100 ^ KEY);
    tick();
    chk("rd_second_pc", if_pc_o, 32'h104);

    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
    tick();
    stall_i = 1'b0; redirect_i = 1'b0;
    chk("sr_valid", if_valid_o, 32'h0);
    chk("sr_pc", if_pc_o, 32'h0);
    chk("sr_inst", if_inst_o, 32'h0);
    for (int n = 0; n < 20 && !if_valid_o; n++) tick();
    chk("sr_first_valid", if_valid_o, 32'h1);
    chk("sr_first_pc", if_pc_o, 32'h200);
    chk("sr_first_inst", if_inst_o, 32'h200 ^ KEY);

    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    for (int n = 0; n < 20 && !if_valid_o; n++) tick();
    chk("wrap_top_pc", if_pc_o, 32'hFFFF_FFFC);
    chk("wrap_top_inst", if_inst_o, 32'h5A5A_FFFC);
    tick();
    chk("wrap_zero_valid", if_valid_o, 32'h1);
    chk("wrap_zero_pc", if_pc_o, 32'h0);
    chk("wrap_zero_inst", if_inst_o, 32'hA5A5_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Upstream neighbour of the decode stage. It generates sequential PCs, issues word fetches over a req/gnt/rvalid instruction-memory handshake, and buffers returned words in a small prefetch FIFO. It presents one registered {pc, inst, valid} per cycle to decode, which consumes pc_i/inst_i. It honours a downstream stall and a redirect (flush plus new target), which is the hook for future branch/jump support.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, prefetch entries; power of 2, >= 2
MAX_OUTST, 2, maximum granted but unreturned requests; 1..FIFO_DEPTH

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
stall_i  in  1  downstream cannot accept; hold output register
redirect_i  in  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  in  32  new fetch address; bits [1:0] ignored and forced to 0
mem_req_o  out  1  fetch request valid
mem_addr_o  out  32  word-aligned fetch address (current PC)
mem_gnt_i  in  1  request accepted this cycle (req && gnt = handshake)
mem_rvalid_i  in  1  read data valid; responses are in order, at least 1 cycle after grant
mem_rdata_i  in  32  instruction word
if_valid_o  out  1  if_pc_o/if_inst_o hold a real instruction
if_pc_o  out  32  PC of presented instruction
if_inst_o  out  32  instruction word; 32'h0 (NOP) when not valid

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC; FIFO empty; outst=0; drop=0; if_valid_o=0; if_pc_o=0; if_inst_o=0; mem_req_o=0. Reset wins over all other inputs.
- Request issue (combinational): mem_req_o = !rst && !redirect_i && (fifo_count + outst < FIFO_DEPTH) && (outst < MAX_OUTST). mem_addr_o=pc. The address holds while req is high and gnt is low. On req&&gnt: pc<=pc+4, with modulo-2^32 wrap (0xFFFF_FFFC -> 0).
- outst update: +1 on grant, -1 on rvalid. Simultaneous grant and rvalid leave it unchanged.
- Response path: on rvalid, if drop>0 then drop<=drop-1 and the data is discarded. Otherwise {pc_of_response, rdata} is pushed. The response PC comes from an internal in-order tag queue of granted addresses (depth MAX_OUTST). The space check guarantees a push never overflows. An rvalid with outst==0 is a protocol error; it is ignored and asserts in simulation.
- Output register:
  - stall_i=1 and no redirect: hold all outputs; FIFO does not pop.
  - stall_i=0: if the FIFO is non-empty, pop the head into the output (valid=1). Else load NOP (valid=0, pc=0, inst=0).
  - Empty FIFO plus a same-cycle rvalid: no bypass. The word reaches the output the following cycle.
- Latency: grant at cycle N, rvalid at N+k (k>=1), if_valid_o at N+k+1 given no stall and an empty FIFO. Zero-wait memory (gnt=1, k=1) sustains 1 instruction/cycle after a 3-cycle startup from reset release.
- Redirect (redirect_i=1 at edge, priority over stall):
  - pc<=redirect_pc_i&~3.
  - FIFO and tag queue cleared; output register loaded with NOP.
  - drop <= outst - (rvalid ? 1 : 0); an rvalid in the redirect cycle is discarded.
  - mem_req_o=0 in the redirect cycle, so no grant is possible.
  - Fetch resumes the next cycle, even while drop>0 (in-order responses make this safe). outst keeps counting the in-flight requests that will be dropped.
- Back-to-back redirects: the latest target wins; drop is recomputed each time from outst.
- Full FIFO with stall held: requests stop. Occupancy plus outstanding never exceeds FIFO_DEPTH.

Decomposition:
- Shared defines header gains: InstAddrBus/InstBus widths (existing), ZeroWord, NOP inst constant, RESET_PC default, and a FetchDepthLog2 macro.
- One natural sub-module, fetch_fifo: synchronous FIFO with clear, count, push/pop. It is instantiated twice, for the data queue {pc, inst} and the tag queue (pc).
- The top level holds the pc counter, outst/drop counters, request gating and output register.

Test Plan:
- Reset: hold rst 3 cycles with RESET_PC=0 -> mem_req_o=0 and all outputs 0. First cycle after release: mem_req_o=1, mem_addr_o=0x0.
- Streaming: gnt=1, rvalid one cycle after each grant, rdata=addr^0xA5A5_0000 -> if_pc_o=0,4,8,... on consecutive cycles, each with the matching inst and if_valid_o=1.
- Stall/backpressure: stall_i=1 for 10 cycles mid-stream -> output constant. mem_req_o drops once FIFO+outst=4, and no words are lost or duplicated after release.
- Redirect with in-flight: 2 outstanding at addr 0x10/0x14, redirect_pc_i=0x103 -> both responses dropped, next mem_addr_o=0x100, and the first valid output has pc 0x100.
- Redirect during stall, same cycle: redirect wins -> output NOP next cycle, refetch from target.
- Wrap: redirect to 0xFFFF_FFFC, gnt=1 -> consecutive outputs pc 0xFFFF_FFFC then 0x0000_0000.
